// File: rtl/mul_hilo_unit_if.sv
// rtl/mul_hilo_unit_if.sv - decode-side command bus and HI/LO result bus of the multiply unit
interface mul_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             ALUOp;
  logic             MULOp;
  logic [5:0]       Func;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Stall;
  logic             Busy;
  logic [WIDTH-1:0] Result;
  logic             ResultValid;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, ALUOp, MULOp, Func, A, B, Flush,
    input  Stall, Busy, Result, ResultValid, HI, LO
  );

  modport slave (
    input  Start, ALUOp, MULOp, Func, A, B, Flush,
    output Stall, Busy, Result, ResultValid, HI, LO
  );
endinterface

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - iterative HI/LO multiply, multiply-accumulate and move unit
module mul_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic           Clock,
  input  logic           nReset,
  mul_hilo_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // What FIN does with the finished product.
  typedef enum logic [1:0] {
    K_SET = 2'd0,
    K_ADD = 2'd1,
    K_SUB = 2'd2,
    K_MUL = 2'd3
  } kind_t;

  state_t state, state_next;

  logic dec_valid, dec_long, dec_signed;
  logic dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
  kind_t dec_kind;

  logic busy, stall, accept;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] p_final;
  logic [2*WIDTH-1:0] hilo_add;
  logic [2*WIDTH-1:0] hilo_sub;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     step_sum;
  logic               neg;
  kind_t              kind_r;

  logic [WIDTH-1:0] hi, lo, result;
  logic             result_valid;

  // Command decode; SPECIAL2 (MULOp) wins over SPECIAL (ALUOp).
  always_comb begin
    dec_valid  = 1'b0;
    dec_long   = 1'b0;
    dec_signed = 1'b0;
    dec_kind   = K_SET;
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    if (bus.MULOp) begin
      case (bus.Func)
        6'h00: begin dec_valid = 1'b1; dec_long = 1'b1; dec_signed = 1'b1; dec_kind = K_ADD; end
        6'h01: begin dec_valid = 1'b1; dec_long = 1'b1; dec_kind = K_ADD; end
        6'h02: begin dec_valid = 1'b1; dec_long = 1'b1; dec_signed = 1'b1; dec_kind = K_MUL; end
        6'h04: begin dec_valid = 1'b1; dec_long = 1'b1; dec_signed = 1'b1; dec_kind = K_SUB; end
        6'h05: begin dec_valid = 1'b1; dec_long = 1'b1; dec_kind = K_SUB; end
        default: ;
      endcase
    end else if (bus.ALUOp) begin
      case (bus.Func)
        6'h10: begin dec_valid = 1'b1; dec_mfhi = 1'b1; end
        6'h11: begin dec_valid = 1'b1; dec_mthi = 1'b1; end
        6'h12: begin dec_valid = 1'b1; dec_mflo = 1'b1; end
        6'h13: begin dec_valid = 1'b1; dec_mtlo = 1'b1; end
        6'h18: begin dec_valid = 1'b1; dec_long = 1'b1; dec_signed = 1'b1; end
        6'h19: begin dec_valid = 1'b1; dec_long = 1'b1; end
        default: ;
      endcase
    end
  end

  // A flush in the same cycle as Start suppresses acceptance of that command.
  assign accept = bus.Start & ~busy & ~bus.Flush & dec_valid;

  // Operand magnitudes; negating 0x80000000 yields 0x80000000, which is correct read as unsigned.
  always_comb begin
    a_abs = (dec_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_abs = (dec_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // One shift-add step: add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
    p_final  = neg ? -prod : prod;
    hilo_add = {hi, lo} + p_final;
    hilo_sub = {hi, lo} - p_final;
  end

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic: IDLE -> MUL -> FIN -> IDLE, flush aborts to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && dec_long) state_next = S_MUL;
      S_MUL: begin
        if (bus.Flush)                   state_next = S_IDLE;
        else if (cnt == CW'(WIDTH - 1))  state_next = S_FIN;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs; no-op codes are never stalled.
  always_comb begin
    busy  = (state != S_IDLE);
    stall = bus.Start & busy & dec_valid;
  end

  // Datapath: moves at accept, one product bit per MUL cycle, architectural update in FIN.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt          <= '0;
      prod         <= '0;
      a_mag        <= '0;
      neg          <= 1'b0;
      kind_r       <= K_SET;
      hi           <= '0;
      lo           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec_mthi) hi <= bus.A;
            if (dec_mtlo) lo <= bus.A;
            if (dec_mfhi) begin
              result       <= hi;
              result_valid <= 1'b1;
            end
            if (dec_mflo) begin
              result       <= lo;
              result_valid <= 1'b1;
            end
            if (dec_long) begin
              a_mag  <= a_abs;
              prod   <= {{WIDTH{1'b0}}, b_abs};
              neg    <= dec_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              kind_r <= dec_kind;
              cnt    <= '0;
            end
          end
        end
        S_MUL: begin
          if (bus.Flush) begin
            cnt <= '0;
          end else begin
            prod <= {step_sum, prod[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
          end
        end
        S_FIN: begin
          cnt <= '0;
          if (!bus.Flush) begin
            case (kind_r)
              K_SET: {hi, lo} <= p_final;
              K_ADD: {hi, lo} <= hilo_add;
              K_SUB: {hi, lo} <= hilo_sub;
              K_MUL: begin
                result       <= p_final[WIDTH-1:0];
                result_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy        = busy;
  assign bus.Stall       = stall;
  assign bus.HI          = hi;
  assign bus.LO          = lo;
  assign bus.Result      = result;
  assign bus.ResultValid = result_valid;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - scoreboard bench for mul_hilo_unit with a behavioural HI/LO model
module tb_mul_hilo_unit;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;
  always #5 Clock = ~Clock;

  mul_hilo_unit_if #(.WIDTH(32)) bus ();
  mul_hilo_unit #(.WIDTH(32)) dut (.Clock(Clock), .nReset(nReset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] exp_q[$];
  logic [31:0] corners[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_cmd(input bit alu, input bit mop, input logic [5:0] fn);
    if (mop) return fn inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05};
    if (alu) return fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19};
    return 1'b0;
  endfunction

  // Architectural effect of one accepted command, in program order.
  task automatic model(input bit alu, input bit mop, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sp, up, hl;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    hl = {m_hi, m_lo};
    if (mop) begin
      case (fn)
        6'h00: hl = hl + sp;
        6'h01: hl = hl + up;
        6'h02: exp_q.push_back(sp[31:0]);
        6'h04: hl = hl - sp;
        6'h05: hl = hl - up;
        default: ;
      endcase
    end else if (alu) begin
      case (fn)
        6'h10: exp_q.push_back(m_hi);
        6'h11: hl[63:32] = a;
        6'h12: exp_q.push_back(m_lo);
        6'h13: hl[31:0] = a;
        6'h18: hl = sp;
        6'h19: hl = up;
        default: ;
      endcase
    end
    {m_hi, m_lo} = hl;
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue(input bit alu, input bit mop, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, output int stalls);
    int guard;
    stalls = 0;
    bus.Start = 1'b1; bus.ALUOp = alu; bus.MULOp = mop; bus.Func = fn; bus.A = a; bus.B = b;
    #1;
    if (is_cmd(alu, mop, fn)) begin
      guard = 0;
      while (bus.Busy === 1'b1 && guard < 100) begin
        chk("stall_while_busy", {63'd0, bus.Stall}, 64'd1);
        stalls++;
        guard++;
        @(negedge Clock);
        #1;
      end
      if (guard >= 100) chk("accept_timeout", 64'(guard), 64'd0);
      chk("stall_when_idle", {63'd0, bus.Stall}, 64'd0);
      model(alu, mop, fn, a, b);
    end else begin
      chk("noop_never_stalls", {63'd0, bus.Stall}, 64'd0);
    end
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    bus.ALUOp = 1'($urandom);
    bus.MULOp = 1'($urandom);
    bus.Func  = 6'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.Busy !== 1'b0 && g < 200) begin
      @(negedge Clock);
      g++;
    end
    if (g >= 200) chk("idle_timeout", 64'(g), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  // Monitor: every ResultValid pulse must match the oldest expected result.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clock);
      if (bus.ResultValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h expected=none", bus.Result);
        end else begin
          e = exp_q.pop_front();
          chk("result", {32'd0, bus.Result}, {32'd0, e});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n;
    logic [31:0] old_hi, old_lo, old_res;
    bit alu, mop;
    logic [5:0] fn;
    bus.Start = 1'b0; bus.ALUOp = 1'b0; bus.MULOp = 1'b0; bus.Func = '0;
    bus.A = '0; bus.B = '0; bus.Flush = 1'b0;

    repeat (3) @(negedge Clock);
    bus.Start = 1'b1; bus.ALUOp = 1'b1; bus.Func = 6'h18;
    #1;
    chk("reset_busy", {63'd0, bus.Busy}, 64'd0);
    chk("reset_stall", {63'd0, bus.Stall}, 64'd0);
    chk("reset_hi", {32'd0, bus.HI}, 64'd0);
    chk("reset_lo", {32'd0, bus.LO}, 64'd0);
    chk("reset_result", {32'd0, bus.Result}, 64'd0);
    chk("reset_rvalid", {63'd0, bus.ResultValid}, 64'd0);
    bus.Start = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;

    // Latency and signed MULT corner.
    old_hi = m_hi;
    issue(1, 0, 6'h18, 32'hFFFF_FFFF, 32'd2, st);
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      if (n == 32) chk("hi_before_fin", {32'd0, bus.HI}, {32'd0, old_hi});
      n++;
      @(negedge Clock);
    end
    chk("busy_cycles", 64'(n), 64'd33);
    chk("mult_hi", {32'd0, bus.HI}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, bus.LO}, 64'hFFFF_FFFE);

    issue(1, 0, 6'h19, 32'hFFFF_FFFF, 32'd2, st);
    issue(1, 0, 6'h10, 0, 0, st);
    issue(1, 0, 6'h12, 0, 0, st);
    issue(1, 0, 6'h18, 32'h8000_0000, 32'h8000_0000, st);
    issue(1, 0, 6'h10, 0, 0, st);
    issue(1, 0, 6'h12, 0, 0, st);
    issue(1, 0, 6'h19, 32'h8000_0000, 32'h8000_0000, st);
    issue(1, 0, 6'h10, 0, 0, st);
    issue(1, 0, 6'h12, 0, 0, st);

    // Accumulate / subtract carry across the HI/LO boundary.
    issue(1, 0, 6'h11, 32'd0, 0, st);
    issue(1, 0, 6'h13, 32'hFFFF_FFFF, 0, st);
    issue(0, 1, 6'h01, 32'd1, 32'd1, st);
    wait_idle();
    chk("maddu_hi", {32'd0, bus.HI}, 64'd1);
    chk("maddu_lo", {32'd0, bus.LO}, 64'd0);
    issue(0, 1, 6'h04, 32'd1, 32'd1, st);
    wait_idle();
    chk("msub_hi", {32'd0, bus.HI}, 64'd0);
    chk("msub_lo", {32'd0, bus.LO}, 64'hFFFF_FFFF);

    // MFLO held behind a multiply.
    issue(1, 0, 6'h18, 32'd3, 32'd5, st);
    @(negedge Clock);
    issue(1, 0, 6'h12, 0, 0, st);
    chk("mflo_stall_cycles", 64'(st), 64'd32);
    wait_idle();

    // MUL result pulse, HI/LO untouched.
    issue(0, 1, 6'h02, 32'd7, 32'hFFFF_FFFD, st);
    wait_idle();
    chk("mul_result", {32'd0, bus.Result}, 64'hFFFF_FFEB);
    @(negedge Clock);
    chk("rv_single_cycle", {63'd0, bus.ResultValid}, 64'd0);
    chk("mul_keeps_hi", {32'd0, bus.HI}, {32'd0, m_hi});
    chk("mul_keeps_lo", {32'd0, bus.LO}, {32'd0, m_lo});

    // Flush at counter 10.
    old_res = bus.Result;
    issue(0, 1, 6'h02, 32'd7, 32'd9, st);
    void'(exp_q.pop_back());
    repeat (10) @(negedge Clock);
    bus.Flush = 1'b1;
    @(negedge Clock);
    bus.Flush = 1'b0;
    chk("flush_busy", {63'd0, bus.Busy}, 64'd0);
    chk("flush_result", {32'd0, bus.Result}, {32'd0, old_res});
    chk("flush_hi", {32'd0, bus.HI}, {32'd0, m_hi});
    repeat (40) @(negedge Clock);

    // Flush with Start: MTHI dropped; flush in IDLE harmless.
    bus.Start = 1'b1; bus.ALUOp = 1'b1; bus.MULOp = 1'b0; bus.Func = 6'h11;
    bus.A = 32'hDEAD_BEEF; bus.Flush = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    issue(1, 0, 6'h10, 0, 0, st);

    // Asynchronous reset mid-multiply.
    issue(1, 0, 6'h11, 32'h1234_5678, 0, st);
    issue(1, 0, 6'h13, 32'h1234_5678, 0, st);
    issue(1, 0, 6'h18, $urandom, $urandom, st);
    repeat (10) @(negedge Clock);
    #2;
    nReset = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("async_rst_hi", {32'd0, bus.HI}, 64'd0);
    chk("async_rst_lo", {32'd0, bus.LO}, 64'd0);
    chk("async_rst_result", {32'd0, bus.Result}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge Clock);
    nReset = 1'b1;
    issue(1, 0, 6'h10, 0, 0, st);

    // Randomised command stream, including no-ops and ALUOp+MULOp overlap.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 13);
      alu = 1'b0; mop = 1'b0; fn = '0;
      case (r)
        0: begin alu = 1; fn = 6'h10; end
        1: begin alu = 1; fn = 6'h11; end
        2: begin alu = 1; fn = 6'h12; end
        3: begin alu = 1; fn = 6'h13; end
        4: begin alu = 1; fn = 6'h18; end
        5: begin alu = 1; fn = 6'h19; end
        6: begin mop = 1; alu = 1'($urandom); fn = 6'h00; end
        7: begin mop = 1; alu = 1'($urandom); fn = 6'h01; end
        8: begin mop = 1; alu = 1'($urandom); fn = 6'h02; end
        9: begin mop = 1; alu = 1'($urandom); fn = 6'h04; end
        10: begin mop = 1; alu = 1'($urandom); fn = 6'h05; end
        11: begin fn = 6'($urandom); end
        12: begin alu = 1; fn = 6'h3F; end
        default: begin mop = 1; alu = 1'($urandom); fn = 6'h03; end
      endcase
      issue(alu, mop, fn, pick(), pick(), st);
      if ($urandom_range(0, 4) == 0) @(negedge Clock);
    end
    wait_idle();
    issue(1, 0, 6'h10, 0, 0, st);
    issue(1, 0, 6'h12, 0, 0, st);
    repeat (5) @(negedge Clock);
    chk("final_hi", {32'd0, bus.HI}, {32'd0, m_hi});
    chk("final_lo", {32'd0, bus.LO}, {32'd0, m_lo});
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
